neuron_mac: RTL and testbench

//   Single-neuron datapath stage placed directly downstream of the network controller.

---
 rtl/neuron_mac.sv | 200 ++++++++++++++++++++
 tb/tb_neuron_mac.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron multiply-accumulate stage behind the network controller.
//
// Stage 1 registers x_in*w_in together with the controller's index. Stage 2 is a three-state
// FSM that accumulates one vector of N_INPUTS products in strict index order, adds the bias,
// and emits a ReLU'd and saturated result.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst      asynchronous active-high reset
//   i_ld       controller strobe: i_x_in / i_w_in / i_index valid this cycle
//   i_index    element index for this ld (legal 0..N_INPUTS-1)
//   i_x_in     signed input sample
//   i_w_in     signed weight
//   i_bias     signed bias, must stay stable while o_busy is high
//   o_y_out    unsigned neuron result, held until the next result
//   o_y_valid  one-cycle pulse when o_y_out is updated
//   o_busy     high while any vector is in flight
//   o_err      one-cycle pulse when an ld is rejected
module neuron_mac #(
    parameter int N_INPUTS = 4,
    parameter int IN_W     = 8,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ld,
    input  logic [15:0]       i_index,
    input  logic [IN_W-1:0]   i_x_in,
    input  logic [IN_W-1:0]   i_w_in,
    input  logic [2*IN_W-1:0] i_bias,
    output logic [OUT_W-1:0]  o_y_out,
    output logic              o_y_valid,
    output logic              o_busy,
    output logic              o_err
);

    localparam int PW = 2 * IN_W;

    typedef enum logic [1:0] {StIdle, StAcc, StFinish} state_t;

    // Stage 1 registers
    logic [PW-1:0]    r_p;
    logic [15:0]      r_p_idx;
    logic             r_p_vld;

    // Stage 2 registers
    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [15:0]      r_cnt;
    logic [OUT_W-1:0] r_y_out;
    logic             r_y_valid;
    logic             r_err;

    state_t           w_state_nxt;
    state_t           w_first_state;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [15:0]      w_cnt_nxt;
    logic [OUT_W-1:0] w_y_out_nxt;
    logic             w_y_valid_nxt;
    logic             w_err_nxt;

    logic [PW-1:0]    w_x_ext;
    logic [PW-1:0]    w_w_ext;
    logic [PW-1:0]    w_prod;
    logic [ACC_W-1:0] w_p_ext;
    logic [ACC_W-1:0] w_bias_ext;
    logic [ACC_W-1:0] w_sum;
    logic [OUT_W-1:0] w_sat;
    logic             w_idx_zero;
    logic             w_idx_seq;
    logic             w_idx_last;

    // Sign-extending both operands to the product width makes the low PW bits of an
    // unsigned multiply equal to the exact signed product.
    assign w_x_ext = {{IN_W{i_x_in[IN_W-1]}}, i_x_in};
    assign w_w_ext = {{IN_W{i_w_in[IN_W-1]}}, i_w_in};
    assign w_prod  = w_x_ext * w_w_ext;

    assign w_p_ext    = {{(ACC_W-PW){r_p[PW-1]}}, r_p};
    assign w_bias_ext = {{(ACC_W-PW){i_bias[PW-1]}}, i_bias};
    assign w_sum      = r_acc + w_bias_ext;

    // ReLU then clamp: negative -> 0, any set bit above OUT_W -> all ones.
    always_comb begin
        if (w_sum[ACC_W-1]) begin
            w_sat = '0;
        end else if (|w_sum[ACC_W-2:OUT_W]) begin
            w_sat = '1;
        end else begin
            w_sat = w_sum[OUT_W-1:0];
        end
    end

    assign w_idx_zero    = (r_p_idx == 16'd0);
    assign w_idx_seq     = (r_p_idx == r_cnt);
    assign w_idx_last    = (r_p_idx == 16'(N_INPUTS - 1));
    // A one-element vector is complete as soon as index 0 is accepted.
    assign w_first_state = (N_INPUTS == 1) ? StFinish : StAcc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p     <= '0;
            r_p_idx <= '0;
            r_p_vld <= 1'b0;
        end else begin
            r_p_vld <= i_ld;
            if (i_ld) begin
                r_p     <= w_prod;
                r_p_idx <= i_index;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_y_out_nxt   = r_y_out;
        w_y_valid_nxt = 1'b0;
        w_err_nxt     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_p_vld) begin
                    if (w_idx_zero) begin
                        w_acc_nxt   = w_p_ext;
                        w_cnt_nxt   = 16'd1;
                        w_state_nxt = w_first_state;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            StAcc: begin
                if (r_p_vld) begin
                    if (w_idx_zero) begin
                        w_acc_nxt = w_p_ext;
                        w_cnt_nxt = 16'd1;
                    end else if (w_idx_seq) begin
                        w_acc_nxt = r_acc + w_p_ext;
                        w_cnt_nxt = r_cnt + 16'd1;
                        if (w_idx_last) begin
                            w_state_nxt = StFinish;
                        end
                    end else begin
                        // Gap, repeat or out-of-range index: drop the partial sum.
                        w_err_nxt   = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = StIdle;
                    end
                end
            end
            StFinish: begin
                // Result uses the pre-edge accumulator; a new vector may start this same edge.
                w_y_out_nxt   = w_sat;
                w_y_valid_nxt = 1'b1;
                w_acc_nxt     = '0;
                w_cnt_nxt     = '0;
                w_state_nxt   = StIdle;
                if (r_p_vld) begin
                    if (w_idx_zero) begin
                        w_acc_nxt   = w_p_ext;
                        w_cnt_nxt   = 16'd1;
                        w_state_nxt = w_first_state;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_y_out   <= '0;
            r_y_valid <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_y_out   <= w_y_out_nxt;
            r_y_valid <= w_y_valid_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign o_y_out   = r_y_out;
    assign o_y_valid = r_y_valid;
    assign o_err     = r_err;
    assign o_busy    = (r_state != StIdle) | r_p_vld;

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: self-checking bench for neuron_mac. Directed scenarios plus randomized
// vectors checked against an arithmetic reference (sum of x*w plus bias, ReLU, clamp).
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld = 1'b0;
    logic [15:0] index = '0;
    logic [7:0]  x_in = '0;
    logic [7:0]  w_in = '0;
    logic [15:0] bias = '0;
    logic [7:0]  y_out;
    logic        y_valid;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_ld_cyc = 0;

    // Observed results and error pulses, tagged with the clock edge that produced them
    int vq_y[$];
    int vq_c[$];
    int eq_c[$];

    int vx[4];
    int vw[4];

    neuron_mac #(
        .N_INPUTS(4),
        .IN_W    (8),
        .ACC_W   (24),
        .OUT_W   (8)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_ld     (ld),
        .i_index  (index),
        .i_x_in   (x_in),
        .i_w_in   (w_in),
        .i_bias   (bias),
        .o_y_out  (y_out),
        .o_y_valid(y_valid),
        .o_busy   (busy),
        .o_err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (y_valid) begin
                vq_y.push_back(int'(y_out));
                vq_c.push_back(cyc);
            end
            if (err) eq_c.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer dot product plus bias, then ReLU and clamp to 8 bits.
    function automatic int ref_y(input int b);
        int s;
        s = b;
        for (int i = 0; i < 4; i++) s += vx[i] * vw[i];
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        vq_y.delete();
        vq_c.delete();
        eq_c.delete();
    endtask

    task automatic send(input int idx, input int x, input int w);
        ld    = 1'b1;
        index = 16'(idx);
        x_in  = 8'(x);
        w_in  = 8'(w);
        tick();
        last_ld_cyc = cyc;
        ld = 1'b0;
    endtask

    task automatic send_vector(input int stall_max);
        for (int i = 0; i < 4; i++) begin
            send(i, vx[i], vw[i]);
            if (stall_max > 0 && i < 3) begin
                repeat ($urandom_range(0, stall_max)) tick();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (y_out !== 8'd0) begin
            n_fail++; $display("FAIL reset_y_out: got %0d want 0", y_out);
        end
        n_checks++;
        if (y_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_y_valid: got %b want 0", y_valid);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int k, exp, got_y, got_c;
        bias = 16'd0;
        vx = '{1, 2, 3, 4};
        vw = '{2, 2, 2, 2};
        exp = ref_y(0);
        clear_mon();
        send_vector(0);
        k = last_ld_cyc;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_busy_inflight: got %b want 1", busy);
        end
        repeat (4) tick();
        got_y = (vq_y.size() > 0) ? vq_y[0] : -1;
        got_c = (vq_c.size() > 0) ? vq_c[0] : -1;
        n_checks++;
        if (vq_y.size() != 1) begin
            n_fail++; $display("FAIL basic_valid_count: got %0d want 1", vq_y.size());
        end
        n_checks++;
        if (got_y != exp) begin
            n_fail++; $display("FAIL basic_y_out: got %0d want %0d", got_y, exp);
        end
        n_checks++;
        if (got_c != k + 2) begin
            n_fail++; $display("FAIL basic_latency: valid at edge %0d want %0d", got_c, k + 2);
        end
        n_checks++;
        if (eq_c.size() != 0) begin
            n_fail++; $display("FAIL basic_err: got %0d err pulses want 0", eq_c.size());
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_relu();
        int exp, got_y;
        bias = 16'd0;
        vx = '{-10, -10, -10, -10};
        vw = '{10, 10, 10, 10};
        exp = ref_y(0);
        clear_mon();
        send_vector(0);
        repeat (4) tick();
        got_y = (vq_y.size() > 0) ? vq_y[0] : -1;
        n_checks++;
        if (vq_y.size() != 1 || got_y != exp) begin
            n_fail++;
            $display("FAIL relu_neg: count %0d y %0d want count 1 y %0d", vq_y.size(), got_y, exp);
        end
    endtask

    task automatic test_saturate();
        int biases[3];
        int exp, got_y;
        biases = '{0, 300, -1};
        for (int t = 0; t < 3; t++) begin
            bias = 16'(biases[t]);
            vx = (t == 0) ? '{127, 127, 127, 127} : '{0, 0, 0, 0};
            vw = '{127, 127, 127, 127};
            exp = ref_y(biases[t]);
            clear_mon();
            send_vector(0);
            repeat (4) tick();
            got_y = (vq_y.size() > 0) ? vq_y[0] : -1;
            n_checks++;
            if (vq_y.size() != 1 || got_y != exp) begin
                n_fail++;
                $display("FAIL saturate_%0d: count %0d y %0d want count 1 y %0d",
                         t, vq_y.size(), got_y, exp);
            end
        end
    endtask

    task automatic test_gap();
        int k, got_c, exp, got_y;
        bias = 16'd0;
        clear_mon();
        send(0, 1, 1);
        send(1, 1, 1);
        send(3, 1, 1);
        k = last_ld_cyc;
        repeat (4) tick();
        got_c = (eq_c.size() > 0) ? eq_c[0] : -1;
        n_checks++;
        if (eq_c.size() != 1 || got_c != k + 1) begin
            n_fail++;
            $display("FAIL gap_err: count %0d at edge %0d want count 1 at edge %0d",
                     eq_c.size(), got_c, k + 1);
        end
        n_checks++;
        if (vq_y.size() != 0) begin
            n_fail++; $display("FAIL gap_no_valid: got %0d results want 0", vq_y.size());
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL gap_busy: got %b want 0", busy);
        end
        bias = 16'd5;
        vx = '{1, 1, 1, 1};
        vw = '{1, 1, 1, 1};
        exp = ref_y(5);
        clear_mon();
        send_vector(0);
        repeat (4) tick();
        got_y = (vq_y.size() > 0) ? vq_y[0] : -1;
        n_checks++;
        if (vq_y.size() != 1 || got_y != exp || eq_c.size() != 0) begin
            n_fail++;
            $display("FAIL gap_recover: count %0d y %0d errs %0d want count 1 y %0d errs 0",
                     vq_y.size(), got_y, eq_c.size(), exp);
        end
    endtask

    task automatic test_async_reset();
        bias = 16'd0;
        clear_mon();
        send(0, 1, 1);
        send(1, 1, 1);
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL areset_busy_before: got %b want 1", busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (y_out !== 8'd0 || busy !== 1'b0 || y_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_outputs: y_out %0d busy %b y_valid %b want 0 0 0",
                     y_out, busy, y_valid);
        end
        tick();
        rst = 1'b0;
        clear_mon();
        send(2, 1, 1);
        repeat (3) tick();
        n_checks++;
        if (eq_c.size() != 1 || vq_y.size() != 0) begin
            n_fail++;
            $display("FAIL areset_lone_idx2: errs %0d results %0d want 1 0",
                     eq_c.size(), vq_y.size());
        end
    endtask

    task automatic test_back_to_back();
        int ka, exp_a, exp_b, ya, yb, ca, cb;
        bias = 16'd0;
        clear_mon();
        vx = '{1, 1, 1, 1};
        vw = '{1, 1, 1, 1};
        exp_a = ref_y(0);
        send_vector(0);
        ka = last_ld_cyc;
        vx = '{2, 2, 2, 2};
        vw = '{3, 3, 3, 3};
        exp_b = ref_y(0);
        send_vector(0);
        repeat (4) tick();
        ya = (vq_y.size() > 0) ? vq_y[0] : -1;
        ca = (vq_c.size() > 0) ? vq_c[0] : -1;
        yb = (vq_y.size() > 1) ? vq_y[1] : -1;
        cb = (vq_c.size() > 1) ? vq_c[1] : -1;
        n_checks++;
        if (vq_y.size() != 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d results want 2", vq_y.size());
        end
        n_checks++;
        if (ya != exp_a || ca != ka + 2) begin
            n_fail++;
            $display("FAIL b2b_first: y %0d at %0d want %0d at %0d", ya, ca, exp_a, ka + 2);
        end
        n_checks++;
        if (yb != exp_b || cb != ka + 6) begin
            n_fail++;
            $display("FAIL b2b_second: y %0d at %0d want %0d at %0d", yb, cb, exp_b, ka + 6);
        end
        n_checks++;
        if (eq_c.size() != 0) begin
            n_fail++; $display("FAIL b2b_err: got %0d err pulses want 0", eq_c.size());
        end
    endtask

    task automatic test_random();
        int exp_q[$];
        int b, got;
        bit keep;
        b = 0;
        clear_mon();
        for (int v = 0; v < 24; v++) begin
            // Bias may only change once the previous vector has fully drained.
            keep = (v > 0) && ($urandom_range(0, 1) == 1);
            if (!keep) begin
                repeat (3) tick();
                b = int'($urandom_range(0, 800)) - 400;
                bias = 16'(b);
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    vx[i] = int'($urandom_range(0, 255)) - 128;
                    vw[i] = int'($urandom_range(0, 255)) - 128;
                end else begin
                    vx[i] = int'($urandom_range(0, 31)) - 16;
                    vw[i] = int'($urandom_range(0, 31)) - 16;
                end
            end
            exp_q.push_back(ref_y(b));
            send_vector(2);
        end
        repeat (5) tick();
        n_checks++;
        if (vq_y.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d results want %0d", vq_y.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < vq_y.size()) ? vq_y[i] : -1;
            n_checks++;
            if (got != exp_q[i]) begin
                n_fail++; $display("FAIL rand_y[%0d]: got %0d want %0d", i, got, exp_q[i]);
            end
        end
        n_checks++;
        if (eq_c.size() != 0) begin
            n_fail++; $display("FAIL rand_err: got %0d err pulses want 0", eq_c.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_saturate();
        test_gap();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
